// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-side arbiter.
//   arb_state_e : arbiter FSM state (ARB_IDLE, ARB_GRANT)
//   WR_COUNT_W  : width of the running written-word counter
//   BEAT_CNT_W  : width of the per-grant beat counter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int WR_COUNT_W = 16;
  localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick.
// Finds the first set bit of req strictly after index 'last', wrapping around.
// Ports:
//   req  [NREQ]  : request vector
//   last [SRC_W] : most recently served index
//   any          : at least one request is set
//   pick [SRC_W] : chosen index (only meaningful when any is high)
module rr_priority_picker #(
  parameter int NREQ  = 4,
  parameter int SRC_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] last,
  output logic             any,
  output logic [SRC_W-1:0] pick
);

  logic [NREQ-1:0]  rot;
  logic [SRC_W-1:0] idx;
  logic             found;
  int               offs;

  always_comb begin
    rot   = '0;
    idx   = '0;
    found = 1'b0;
    offs  = 0;
    // Rotate so that rot[0] is the requester right after 'last'.
    for (int k = 0; k < NREQ; k++) begin
      idx    = SRC_W'((int'(last) + 1 + k) % NREQ);
      rot[k] = req[idx];
    end
    // Priority-encode the lowest set bit of the rotated vector.
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        offs  = k;
        found = 1'b1;
      end
    end
    any  = |req;
    // Un-rotate back to an absolute requester index.
    pick = SRC_W'((int'(last) + 1 + offs) % NREQ);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among NREQ producers with
// round-robin arbitration and bursts of at most MAX_BURST beats per grant.
// Ports:
//   wr_clk, reset     : write-domain clock, async active-high reset
//   req_valid/ready   : per-requester handshake; req_data packed WIDTH per requester
//   fifo_full         : FIFO full flag (wr_clk domain)
//   fifo_wr_en/data   : FIFO write strobe and word
//   fifo_wr_src       : index of the granted requester
//   grant_valid       : registered, high while a grant is held
//   wr_count          : words written since reset, wraps at 2^16
//   dbg_state         : current FSM state
// Handshake: a beat transfers when req_valid[i] and req_ready[i] are both high
// in the same cycle; req_ready depends combinationally on fifo_full and the
// current grant only, never on req_valid, and data must stay stable while
// valid is high without ready.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int SRC_W     = $clog2(NREQ)
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  output logic [SRC_W-1:0]      fifo_wr_src,
  output logic                  grant_valid,
  output logic [WR_COUNT_W-1:0] wr_count,
  output arb_state_e            dbg_state
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);
  // Reset so that requester 0 is the first one after 'last'.
  localparam logic [SRC_W-1:0]      LAST_INIT = SRC_W'(NREQ - 1);

  arb_state_e              state_q, state_d;
  logic [SRC_W-1:0]        grant_id_q, grant_id_d;
  logic [SRC_W-1:0]        last_grant_q, last_grant_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WR_COUNT_W-1:0]   wr_count_q, wr_count_d;

  logic                    pick_any;
  logic [SRC_W-1:0]        pick_id;
  logic                    in_grant;
  logic                    cur_valid;
  logic [WIDTH-1:0]        cur_data;
  logic                    beat;

  rr_priority_picker #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_picker (
    .req  (req_valid),
    .last (last_grant_q),
    .any  (pick_any),
    .pick (pick_id)
  );

  // Datapath: everything is gated by the registered state, so an async reset
  // removes any pending write in the same cycle.
  always_comb begin
    in_grant  = (state_q == ARB_GRANT);
    cur_valid = req_valid[grant_id_q];
    cur_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == SRC_W'(i)) cur_data = req_data[i*WIDTH +: WIDTH];
    end
    beat         = in_grant & cur_valid & ~fifo_full;
    req_ready    = '0;
    if (in_grant) req_ready[grant_id_q] = ~fifo_full;
    fifo_wr_en   = beat;
    fifo_wr_data = in_grant ? cur_data : '0;
    fifo_wr_src  = in_grant ? grant_id_q : '0;
  end

  // Next-state logic. fifo_full only blocks beats; it never ends a grant.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    wr_count_d   = wr_count_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          wr_count_d = wr_count_q + WR_COUNT_W'(1);
        end
        if (!cur_valid || (beat && (beat_cnt_q == LAST_BEAT))) begin
          last_grant_d = grant_id_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
      beat_cnt_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign grant_valid = (state_q == ARB_GRANT);
  assign wr_count    = wr_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side scheduler for the asynchronous FIFO. It shares the FIFO write port among `NREQ` producers in the `wr_clk` domain using round-robin arbitration with bounded bursts. It applies backpressure from the FIFO full flag and tags each written word with its source index. It sits between the producer blocks and the FIFO write port, and is entirely synchronous to `wr_clk`.

## Interface
- `WIDTH`, 8: data word width; matches the FIFO width.
- `NREQ`, 4: number of requesters, from 2 to 16.
- `MAX_BURST`, 4: maximum beats per grant, from 1 to 255.
- `SRC_W`, `$clog2(NREQ)`: width of the source index. Derived; do not override.

Ports:
- `wr_clk`  in  1  write-domain clock.
- `reset`  in  1  asynchronous, active-high reset. Clock is `wr_clk`.
- `req_valid`  in  NREQ  per-requester data valid.
- `req_data`  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  per-requester accept. Combinational.
- `fifo_full`  in  1  FIFO full flag, already in the `wr_clk` domain.
- `fifo_wr_en`  out  1  FIFO write strobe. Combinational.
- `fifo_wr_data`  out  WIDTH  word to write.
- `fifo_wr_src`  out  SRC_W  index of the granted requester.
- `grant_valid`  out  1  high while a grant is held. Registered.
- `wr_count`  out  16  total words written since reset; wraps modulo 2^16.

## Operation
- States: `IDLE` and `GRANT`.
- **IDLE**
  - If any `req_valid` bit is high, pick the first requester strictly after `last_grant`, cyclically.
  - Register that index into `grant_id`, set `beat_cnt` to 0, and go to `GRANT`.
  - Otherwise stay in `IDLE`.
- **GRANT** — beat condition: `beat = req_valid[grant_id] & ~fifo_full`.
  - `req_ready[grant_id] = ~fifo_full`. All other `req_ready` bits are 0.
  - `fifo_wr_en = beat`, `fifo_wr_data = req_data[grant_id]`, `fifo_wr_src = grant_id`.
  - On a beat, `beat_cnt` and `wr_count` each increment by 1.
  - Release when either:
    - `req_valid[grant_id]` is low, or
    - a beat occurs with `beat_cnt == MAX_BURST-1`.
  - On release: `last_grant <= grant_id`, go to `IDLE`.
  - While `fifo_full` is high with valid held high: hold the grant, no beat, `beat_cnt` frozen. Full never forces a release.
- In `IDLE`, all `req_ready` bits are 0 and `fifo_wr_en` is 0.
- `beat_cnt` is 8 bits wide. `wr_count` wraps from 16'hFFFF to 0.
- Requesters must hold `req_data` stable while `req_valid` is high and `req_ready` is low.

## Timing
- Reset values:
  - state `IDLE`, `grant_id` 0, `last_grant` NREQ-1 (requester 0 wins first), `beat_cnt` 0, `wr_count` 0.
  - `grant_valid` 0, `req_ready` 0, `fifo_wr_en` 0, `fifo_wr_src` 0, `fifo_wr_data` 0.
- Arbitration latency: 1 cycle from `req_valid` rising to `grant_valid` high. The first beat can occur in the cycle `grant_valid` is high.
- Each release inserts exactly one `IDLE` cycle before the next grant. A continuous stream of bursts therefore sustains `MAX_BURST` beats per `MAX_BURST+1` cycles.
- `fifo_full` rising in the same cycle as a valid beat suppresses that beat: no write, no count increment.
- A requester dropping valid in the release cycle loses nothing: no beat occurs, so no data is dropped.
- Reset asserted mid-burst: outputs take their reset values immediately (asynchronous). No partial write is issued after reset assertion.
- `MAX_BURST = 1`: every beat releases, so fairness is one word per requester.

## Structure
- Package `fifo_arb_pkg`: state enum (`ARB_IDLE`, `ARB_GRANT`) and the `WR_COUNT_W = 16` constant.
- Sub-module `rr_priority_picker`: combinational.
  - Inputs: `req` [NREQ], `last` [SRC_W].
  - Outputs: `any`, `pick` [SRC_W].
  - Logic: rotate, priority-encode, un-rotate.
- Top level holds the FSM, `beat_cnt`, `wr_count`, and the datapath muxing.

## Test plan
- **Reset:** hold `reset` for 3 cycles, then release with no requests. All outputs stay 0 and the state stays `IDLE` for 10 cycles.
- **Single requester, continuous valid:** requester 2 continuously valid with data 8'h10, 8'h11, …, `MAX_BURST=4`, FIFO never full. Expect 4 writes with `fifo_wr_src` = 2, one `IDLE` cycle, then regrant to 2. After 20 words, `wr_count` = 20.
- **Round-robin:** all 4 requesters continuously valid, `MAX_BURST=2`. Source sequence is 0,0,1,1,2,2,3,3,0,0… with one gap cycle between each pair.
- **Backpressure:** assert `fifo_full` for 5 cycles mid-burst of requester 1. `fifo_wr_en` = 0 and `req_ready[1]` = 0 throughout; the grant is held and `beat_cnt` is unchanged. When full drops, the burst completes with the remaining beats and no data is lost or duplicated (scoreboard check).
- **Early release:** requester 3 drops valid after 1 beat of a 4-beat allowance. Release occurs the next cycle, and `last_grant` = 3, so requester 0 wins next.
- **Reset mid-burst / counter wrap:** assert reset during a `GRANT` with a beat pending. `fifo_wr_en` drops in the same cycle, and after release requester 0 is granted first. Separately, preload via 65 536 writes: `wr_count` wraps to 0.
